multicycle_control_unit: RTL

Multi-cycle controller for the RV32I subset core: add, sub, and, or, slt, addi, andi, ori, slti, lw, sw, beq, bne, jal, jalr, plus optional shifts.
- Replaces single-cycle decode with a Moore/Mealy FSM that sequences a shared ALU, one unified memory and the PC/IR registers across several cycles.
- Memory is variable-latency behind a req/ready handshake with a watchdog timeout.
- Illegal instructions and memory timeouts are trapped into a sticky halt state.

---
 rtl/mcu_pkg.sv | 76 +++++++
 rtl/multicycle_control_unit_alu_decoder.sv | 61 ++++++
 rtl/multicycle_control_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, ALU codes,
// mux selects, FSM states and the control-word payload.
package mcu_pkg;

  localparam int unsigned OPCODE_W   = 7;
  localparam int unsigned ALU_CODE_W = 4;
  localparam int unsigned SEL_W      = 2;
  localparam int unsigned STATE_W    = 4;

  localparam logic [OPCODE_W-1:0] OP_NOP    = 7'b0000000;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;

  localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'b0000;
  localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'b0001;
  localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'b0010;
  localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'b0011;
  localparam logic [ALU_CODE_W-1:0] ALU_SLT = 4'b0100;
  localparam logic [ALU_CODE_W-1:0] ALU_SLL = 4'b0101;
  localparam logic [ALU_CODE_W-1:0] ALU_SRL = 4'b0110;
  localparam logic [ALU_CODE_W-1:0] ALU_SRA = 4'b0111;

  localparam logic [SEL_W-1:0] SRCA_PC    = 2'd0;
  localparam logic [SEL_W-1:0] SRCA_OLDPC = 2'd1;
  localparam logic [SEL_W-1:0] SRCA_RS1   = 2'd2;
  localparam logic [SEL_W-1:0] SRCB_RS2   = 2'd0;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'd1;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'd2;
  localparam logic [SEL_W-1:0] RES_ALUOUT = 2'd0;
  localparam logic [SEL_W-1:0] RES_RDATA  = 2'd1;
  localparam logic [SEL_W-1:0] RES_ALU    = 2'd2;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC_R = 4'd6,  EXEC_I = 4'd7,
    ALU_WB = 4'd8,  BRANCH = 4'd9,  JAL    = 4'd10, JALR   = 4'd11,
    LINK   = 4'd12, TRAP   = 4'd13
  } state_t;

  typedef enum logic [3:0] {
    OC_NOP, OC_LOAD, OC_STORE, OC_R, OC_I, OC_BRANCH, OC_JAL, OC_JALR, OC_BAD
  } opclass_t;

  typedef struct packed {
    logic                  mem_req;
    logic                  mem_we;
    logic                  adr_src;
    logic                  ir_write;
    logic                  pc_write;
    logic                  reg_write;
    logic [SEL_W-1:0]      alu_src_a;
    logic [SEL_W-1:0]      alu_src_b;
    logic [SEL_W-1:0]      result_src;
    logic [ALU_CODE_W-1:0] alu_ctrl;
  } ctrl_t;

  function automatic opclass_t decode_opclass(input logic [OPCODE_W-1:0] op);
    case (op)
      OP_NOP:    return OC_NOP;
      OP_LOAD:   return OC_LOAD;
      OP_STORE:  return OC_STORE;
      OP_R:      return OC_R;
      OP_I:      return OC_I;
      OP_BRANCH: return OC_BRANCH;
      OP_JAL:    return OC_JAL;
      OP_JALR:   return OC_JALR;
      default:   return OC_BAD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// Combinational ALU decoder: maps opcode class and funct fields to an ALU code
// and flags encodings outside the supported subset.
module alu_decoder
  import mcu_pkg::*;
#(
  parameter bit SUPPORT_SHIFT = 1'b1
) (
  input  opclass_t              opclass_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  output logic [ALU_CODE_W-1:0] alu_ctrl_o,
  output logic                  illegal_o
);

  logic is_r_c;
  logic f7_zero_c;
  logic f7_alt_c;
  logic shift_c;

  assign is_r_c    = (opclass_i == OC_R);
  assign f7_zero_c = (funct7_i == 7'b0000000);
  assign f7_alt_c  = (funct7_i == 7'b0100000);

  // funct7 only qualifies R-type ops and the I-type shift immediates
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    illegal_o  = 1'b0;
    shift_c    = 1'b0;
    case (opclass_i)
      OC_R, OC_I: begin
        case (funct3_i)
          3'b000: begin
            if (is_r_c) begin
              if (f7_alt_c)        alu_ctrl_o = ALU_SUB;
              else if (!f7_zero_c) illegal_o  = 1'b1;
            end
          end
          3'b010: begin alu_ctrl_o = ALU_SLT; illegal_o = is_r_c && !f7_zero_c; end
          3'b110: begin alu_ctrl_o = ALU_OR;  illegal_o = is_r_c && !f7_zero_c; end
          3'b111: begin alu_ctrl_o = ALU_AND; illegal_o = is_r_c && !f7_zero_c; end
          3'b001: begin alu_ctrl_o = ALU_SLL; shift_c = 1'b1; illegal_o = !f7_zero_c; end
          3'b101: begin
            shift_c = 1'b1;
            if (f7_alt_c)       alu_ctrl_o = ALU_SRA;
            else if (f7_zero_c) alu_ctrl_o = ALU_SRL;
            else                illegal_o  = 1'b1;
          end
          default: illegal_o = 1'b1;
        endcase
        if (shift_c && !SUPPORT_SHIFT) illegal_o = 1'b1;
      end
      OC_BRANCH: begin
        alu_ctrl_o = ALU_SUB;
        illegal_o  = (funct3_i[2:1] != 2'b00);
      end
      OC_BAD:  illegal_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I controller: sequences PC/IR, shared ALU and unified memory,
// with a memory watchdog and a sticky trap state.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W     = 4,
  parameter bit          SUPPORT_SHIFT  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  illegal_instr,
  output logic                  mem_timeout,
  output logic [3:0]            state_dbg
);

  localparam int unsigned WAIT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                illegal_q, illegal_d;
  logic                timeout_q, timeout_d;
  opclass_t            opclass_c;
  logic [ALU_CODE_W-1:0] dec_alu_c;
  logic                dec_illegal_c;
  logic                waiting_c;
  logic                timeout_hit_c;
  ctrl_t               ctrl_c;

  assign opclass_c     = decode_opclass(opcode);
  assign timeout_hit_c = (TIMEOUT_CYCLES != 0) &&
                         ((wait_q + WAIT_W'(1)) == WAIT_W'(TIMEOUT_CYCLES));

  alu_decoder #(
    .SUPPORT_SHIFT (SUPPORT_SHIFT)
  ) u_alu_decoder (
    .opclass_i  (opclass_c),
    .funct3_i   (funct3),
    .funct7_i   (funct7),
    .alu_ctrl_o (dec_alu_c),
    .illegal_o  (dec_illegal_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FETCH;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state and control word; FETCH handshake and branch decision are Mealy
  always_comb begin
    state_d          = state_q;
    wait_d           = '0;
    illegal_d        = illegal_q;
    timeout_d        = timeout_q;
    waiting_c        = 1'b0;
    ctrl_c           = '0;
    ctrl_c.alu_ctrl  = ALU_ADD;
    case (state_q)
      FETCH: begin
        ctrl_c.mem_req = 1'b1;
        if (mem_ready) begin
          ctrl_c.ir_write   = 1'b1;
          ctrl_c.pc_write   = 1'b1;
          ctrl_c.alu_src_a  = SRCA_PC;
          ctrl_c.alu_src_b  = SRCB_FOUR;
          ctrl_c.result_src = RES_ALU;
          state_d           = DECODE;
        end else begin
          waiting_c = 1'b1;
        end
      end
      DECODE: begin
        ctrl_c.alu_src_a = SRCA_OLDPC;
        ctrl_c.alu_src_b = SRCB_IMM;
        if (dec_illegal_c) begin
          state_d   = TRAP;
          illegal_d = 1'b1;
        end else begin
          case (opclass_c)
            OC_LOAD, OC_STORE: state_d = MEMADR;
            OC_R:              state_d = EXEC_R;
            OC_I:              state_d = EXEC_I;
            OC_BRANCH:         state_d = BRANCH;
            OC_JAL:            state_d = JAL;
            OC_JALR:           state_d = JALR;
            default:           state_d = FETCH;
          endcase
        end
      end
      MEMADR: begin
        ctrl_c.alu_src_a = SRCA_RS1;
        ctrl_c.alu_src_b = SRCB_IMM;
        state_d          = (opclass_c == OC_STORE) ? MEMWR : MEMRD;
      end
      MEMRD, MEMWR: begin
        ctrl_c.mem_req = 1'b1;
        ctrl_c.mem_we  = (state_q == MEMWR);
        ctrl_c.adr_src = 1'b1;
        if (mem_ready) state_d = (state_q == MEMRD) ? MEMWB : FETCH;
        else           waiting_c = 1'b1;
      end
      MEMWB: begin
        ctrl_c.result_src = RES_RDATA;
        ctrl_c.reg_write  = 1'b1;
        state_d           = FETCH;
      end
      EXEC_R, EXEC_I: begin
        ctrl_c.alu_src_a = SRCA_RS1;
        ctrl_c.alu_src_b = (state_q == EXEC_I) ? SRCB_IMM : SRCB_RS2;
        ctrl_c.alu_ctrl  = dec_alu_c;
        state_d          = ALU_WB;
      end
      ALU_WB: begin
        ctrl_c.result_src = RES_ALUOUT;
        ctrl_c.reg_write  = 1'b1;
        state_d           = FETCH;
      end
      BRANCH: begin
        ctrl_c.alu_src_a  = SRCA_RS1;
        ctrl_c.alu_src_b  = SRCB_RS2;
        ctrl_c.alu_ctrl   = ALU_SUB;
        ctrl_c.result_src = RES_ALUOUT;
        ctrl_c.pc_write   = (funct3 == 3'b000) ? zero : !zero;
        state_d           = FETCH;
      end
      JAL: begin
        ctrl_c.result_src = RES_ALUOUT;
        ctrl_c.pc_write   = 1'b1;
        state_d           = LINK;
      end
      JALR: begin
        ctrl_c.alu_src_a  = SRCA_RS1;
        ctrl_c.alu_src_b  = SRCB_IMM;
        ctrl_c.result_src = RES_ALU;
        ctrl_c.pc_write   = 1'b1;
        state_d           = LINK;
      end
      LINK: begin
        ctrl_c.alu_src_a  = SRCA_OLDPC;
        ctrl_c.alu_src_b  = SRCB_FOUR;
        ctrl_c.result_src = RES_ALU;
        ctrl_c.reg_write  = 1'b1;
        state_d           = FETCH;
      end
      TRAP:    ;
      default: state_d = FETCH;
    endcase
    // A ready in the final counted cycle never reaches here, so ready wins
    if (waiting_c) begin
      if (timeout_hit_c) begin
        state_d   = TRAP;
        timeout_d = 1'b1;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  assign mem_req       = ctrl_c.mem_req;
  assign mem_we        = ctrl_c.mem_we;
  assign adr_src       = ctrl_c.adr_src;
  assign ir_write      = ctrl_c.ir_write;
  assign pc_write      = ctrl_c.pc_write;
  assign reg_write     = ctrl_c.reg_write;
  assign alu_src_a     = ctrl_c.alu_src_a;
  assign alu_src_b     = ctrl_c.alu_src_b;
  assign result_src    = ctrl_c.result_src;
  assign alu_ctrl      = ALU_CTRL_W'(ctrl_c.alu_ctrl);
  assign illegal_instr = illegal_q;
  assign mem_timeout   = timeout_q;
  assign state_dbg     = STATE_W'(state_q);

endmodule
